// File: rtl/ahb_mst_arbiter_pkg.sv
// Shared AHB-Lite encodings, bus widths and address-phase bundle for the two-master arbiter.
package ahb_mst_arbiter_pkg;

   localparam int HADDR_BUS = 32;
   localparam int HDATA_BUS = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic OWN_LSU = 1'b0;
   localparam logic OWN_IFU = 1'b1;

   typedef enum logic {
      G_LSU = 1'b0,
      G_IFU = 1'b1
   } grant_state_t;

   typedef struct packed {
      logic                 hsel;
      logic [1:0]           htrans;
      logic [HADDR_BUS-1:0] haddr;
      logic                 hwrite;
      logic [2:0]           hsize;
      logic [2:0]           hburst;
      logic [3:0]           hprot;
      logic                 hmastlock;
   } ahb_addr_t;

endpackage

// File: rtl/ahb_arb_grant.sv
// Grant FSM: fixed priority LSU > IFU, or round-robin with a hold counter when ARB_RR_EN is defined.
module ahb_arb_grant
   import ahb_mst_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hready,
   input  logic       m0_req,
   input  logic       m1_req,
   input  logic       lock,
`ifdef ARB_RR_EN
   input  logic       nonseq_acc,
`endif
   output logic       owner,
   output logic [1:0] hgrant
);

   grant_state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      state <= G_IFU;
      else if (hready) state <= state_nxt;
   end

`ifdef ARB_RR_EN
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

   logic         own_req, oth_req;
   logic [3:0]   hold_cnt;
   grant_state_t oth_state;

   assign own_req   = (state == G_IFU) ? m1_req : m0_req;
   assign oth_req   = (state == G_IFU) ? m0_req : m1_req;
   assign oth_state = (state == G_IFU) ? G_LSU : G_IFU;

   always_comb begin
      state_nxt = state;
      if (!lock) begin
         if (own_req) begin
            if (oth_req && nonseq_acc && (hold_cnt == HOLD_LAST)) state_nxt = oth_state;
         end else if (oth_req) begin
            state_nxt = oth_state;
         end
      end
   end

   // counts only while there is contention; saturates at the handover point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_cnt <= '0;
      else if (hready) begin
         if ((state_nxt != state) || !oth_req)          hold_cnt <= '0;
         else if (nonseq_acc && (hold_cnt != HOLD_LAST)) hold_cnt <= hold_cnt + 4'd1;
      end
   end
`else
   localparam int unused_hold_max = HOLD_MAX;

   always_comb begin
      state_nxt = state;
      if (!lock) begin
         if (m0_req)      state_nxt = G_LSU;
         else if (m1_req) state_nxt = G_IFU;
      end
   end
`endif

   assign owner  = (state == G_IFU) ? OWN_IFU : OWN_LSU;
   assign hgrant = {state == G_IFU, state == G_LSU};

endmodule

// File: rtl/ahb_mst_arbiter.sv
// Two-master AHB-Lite arbiter (LSU=M0, IFU=M1). Define ARB_RR_EN for round-robin, else fixed priority.
module ahb_mst_arbiter
   import ahb_mst_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m0_hsel_i,
   input  logic [1:0]           m0_htrans_i,
   input  logic [HADDR_BUS-1:0] m0_haddr_i,
   input  logic                 m0_hwrite_i,
   input  logic [2:0]           m0_hsize_i,
   input  logic [2:0]           m0_hburst_i,
   input  logic [3:0]           m0_hprot_i,
   input  logic                 m0_hmastlock_i,
   input  logic [HDATA_BUS-1:0] m0_hwdata_i,
   input  logic                 m1_hsel_i,
   input  logic [1:0]           m1_htrans_i,
   input  logic [HADDR_BUS-1:0] m1_haddr_i,
   input  logic                 m1_hwrite_i,
   input  logic [2:0]           m1_hsize_i,
   input  logic [2:0]           m1_hburst_i,
   input  logic [3:0]           m1_hprot_i,
   input  logic                 m1_hmastlock_i,
   input  logic [HDATA_BUS-1:0] m1_hwdata_i,
   output logic [1:0]           m_hgrant_o,
   output logic                 m_hready_o,
   output logic [HDATA_BUS-1:0] m_hrdata_o,
   output logic                 s_hsel_o,
   output logic [1:0]           s_htrans_o,
   output logic [HADDR_BUS-1:0] s_haddr_o,
   output logic                 s_hwrite_o,
   output logic [2:0]           s_hsize_o,
   output logic [2:0]           s_hburst_o,
   output logic [3:0]           s_hprot_o,
   output logic                 s_hmastlock_o,
   output logic [HDATA_BUS-1:0] s_hwdata_o,
   input  logic                 s_hready_i,
   input  logic [HDATA_BUS-1:0] s_hrdata_i,
   output logic                 m_owner_o
);

   ahb_addr_t m0_a, m1_a, g_a;
   logic      owner;
   logic      d_valid, d_owner;

   assign m0_a = '{hsel: m0_hsel_i, htrans: m0_htrans_i, haddr: m0_haddr_i, hwrite: m0_hwrite_i,
                   hsize: m0_hsize_i, hburst: m0_hburst_i, hprot: m0_hprot_i, hmastlock: m0_hmastlock_i};
   assign m1_a = '{hsel: m1_hsel_i, htrans: m1_htrans_i, haddr: m1_haddr_i, hwrite: m1_hwrite_i,
                   hsize: m1_hsize_i, hburst: m1_hburst_i, hprot: m1_hprot_i, hmastlock: m1_hmastlock_i};
   assign g_a  = (owner == OWN_IFU) ? m1_a : m0_a;

   ahb_arb_grant #(.HOLD_MAX(HOLD_MAX)) u_grant (
      .clk        (clk),
      .rst_n      (rst_n),
      .hready     (s_hready_i),
      .m0_req     (m0_hsel_i),
      .m1_req     (m1_hsel_i),
      .lock       (g_a.hmastlock),
`ifdef ARB_RR_EN
      .nonseq_acc (s_hready_i && (s_htrans_o == HTRANS_NONSEQ)),
`endif
      .owner      (owner),
      .hgrant     (m_hgrant_o)
   );

   // a deselected owner must not leak a stale transfer type onto the bus
   assign s_hsel_o      = g_a.hsel;
   assign s_htrans_o    = g_a.hsel ? g_a.htrans : HTRANS_IDLE;
   assign s_haddr_o     = g_a.haddr;
   assign s_hwrite_o    = g_a.hwrite;
   assign s_hsize_o     = g_a.hsize;
   assign s_hburst_o    = g_a.hburst;
   assign s_hprot_o     = g_a.hprot;
   assign s_hmastlock_o = g_a.hmastlock;

   assign m_hready_o = s_hready_i;
   assign m_hrdata_o = s_hrdata_i;
   assign m_owner_o  = owner;

   // data phase lags the address phase by one accepted cycle, so it has its own owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_valid <= 1'b0;
         d_owner <= OWN_IFU;
      end else if (s_hready_i) begin
         d_valid <= (s_htrans_o == HTRANS_NONSEQ);
         d_owner <= owner;
      end
   end

   assign s_hwdata_o = !d_valid ? '0 : ((d_owner == OWN_IFU) ? m1_hwdata_i : m0_hwdata_i);

endmodule
